jtag_debug_sysclk_bridge: RTL and testbench
===========================================

Name: jtag_debug_sysclk_bridge

Overview:
Parametrised system-clock side of the CPU JTAG debug module. It synchronises the virtual-JTAG update-DR and update-IR strobes, which arrive from the TCK domain, into clk. It captures the shift register and instruction register into a command FIFO and presents decoded commands to the CPU debug logic over a valid/ready handshake. It replaces the fixed 2-bit IR, 38-bit DR, single-register capture with configurable widths and buffering, so back-to-back JTAG updates are no longer lost.

Parameters:
IR_W, 2, virtual-JTAG instruction width
DR_W, 38, shift-register / command data width
DEPTH, 4, command FIFO entries; power of 2, >=2
SYNC_STAGES, 2, synchroniser flops per strobe; >=2
ACTION_BIT, 35, data bit index that selects take_action (1) or take_no_action (0)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_W  instruction register from TCK domain; quasi-static
sr  in  DR_W  shift register from TCK domain; stable while vs_udr is high and for >=SYNC_STAGES+2 clk afterwards
vs_udr  in  1  virtual update-DR level, TCK domain
vs_uir  in  1  virtual update-IR level, TCK domain
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  consumer accepts head
cmd_ir  out  IR_W  head instruction
cmd_data  out  DR_W  head data (jdo)
cmd_action  out  1  head data[ACTION_BIT]
ir_update  out  1  one-clk pulse on synchronised update-IR
ir_latched  out  IR_W  ir_in captured at last ir_update
overflow  out  1  sticky: an update was dropped because the FIFO was full
overflow_clr  in  1  clears overflow
fill  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all synchroniser and edge flops 0; FIFO empty; cmd_valid=0; fill=0; overflow=0; ir_update=0; ir_latched=0. cmd_ir, cmd_data and cmd_action are 0 when the FIFO is empty.
- Synchroniser: vs_udr and vs_uir each pass through a SYNC_STAGES-flop chain followed by one edge flop.
  - udr_pulse = sync_out & ~edge_q. This is a single-clk pulse per rising edge; held levels produce no repeat.
  - uir_pulse is formed the same way.
- Latency: vs_udr sampled high at edge 1 gives udr_pulse true after edge SYNC_STAGES. The write happens at edge SYNC_STAGES+1, and cmd_valid is high after edge SYNC_STAGES+1 (FIFO previously empty).
- Push on udr_pulse: entry = {ir_in, sr} sampled in the pulse cycle.
- Pop: on cmd_valid & cmd_ready.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; full = (fill==DEPTH); outputs are driven combinationally from the head entry.
- Push while full with no pop in the same cycle: the entry is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle:
  - When full, both are accepted and fill stays at DEPTH.
  - When empty, the push is accepted and the pop is impossible (cmd_valid=0).
- overflow_clr and a drop in the same cycle: overflow stays 1 (set wins).
- uir_pulse: ir_latched <= ir_in and ir_update=1 for that cycle. It is independent of the FIFO, and a simultaneous udr_pulse is handled fully.
- reset_n asserted mid-operation: the FIFO is flushed immediately, and pending synchroniser state is lost. A strobe level still high at deassertion gives a pulse SYNC_STAGES clk later, by design.
- cmd_valid is asserted no earlier than the write edge. Head data is stable while cmd_valid=1 and cmd_ready=0.

Optional Feature:
JTAG_DBG_TIMESTAMP_EN
- Defined:
  - Adds parameter TS_W (default 16), a free-running TS_W counter that wraps, reset to 0, and output cmd_ts[TS_W].
  - Each FIFO entry stores the counter value from its push cycle.
  - cmd_ts follows the head entry and is 0 when the FIFO is empty.
- Undefined: no counter, no cmd_ts port, FIFO width is IR_W+DR_W.

Decomposition:
- Package jtag_debug_pkg: the default IR_W/DR_W/ACTION_BIT constants, the IR opcode localparams (OCIMEM=0, TRACEMEM=1, BREAK=2, TRACECTRL=3), and the entry struct typedef {ir, data[, ts]}.
- One sub-module, jtag_strobe_sync (SYNC_STAGES chain plus edge detect, pulse output), instantiated twice.
- The FIFO stays inline.

Test Plan:
1. Reset, then vs_udr held high 5 clk with sr=38'h2_0000_0ABC, ir_in=2'b01, cmd_ready=0:
   - cmd_valid rises after edge 3 (SYNC_STAGES=2).
   - cmd_data=38'h2_0000_0ABC, cmd_ir=1, cmd_action=0, fill=1.
   - Exactly one entry is pushed.
2. Five vs_udr pulses with distinct sr, cmd_ready=0, DEPTH=4: fill=4, overflow=1, and entries 1-4 pop in order, the fifth being lost. Then overflow_clr=1 for one clk: overflow=0.
3. FIFO full with cmd_ready=1 during the cycle a fifth udr_pulse occurs: the head pops, the new entry is accepted, fill stays 4, overflow stays 0.
4. vs_uir pulse with ir_in=2'b10, coincident with a vs_udr pulse: ir_update is a one-clk pulse, ir_latched=2, and the FIFO also gains an entry.
5. sr bit35=1: cmd_action=1. reset_n low for 1 clk with fill=3: fill=0, cmd_valid=0, and all outputs return to 0 asynchronously.
6. With JTAG_DBG_TIMESTAMP_EN, two udr pulses 10 clk apart: the cmd_ts difference between the two entries is 10. Also check counter wrap at 2^TS_W-1 -> 0.

Source files
------------

// File: rtl/jtag_debug_sysclk_bridge_pkg.sv
// Shared constants and types for the system-clock side of the CPU JTAG debug
// bridge: default widths, IR opcode values and the command FIFO entry layout.
// Optional feature macro: JTAG_DBG_TIMESTAMP_EN (adds a timestamp field).
package jtag_debug_pkg;

  // Default geometry of the virtual-JTAG registers
  localparam int IR_W_DEF        = 2;
  localparam int DR_W_DEF        = 38;
  localparam int ACTION_BIT_DEF  = 35;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
`ifdef JTAG_DBG_TIMESTAMP_EN
  localparam int TS_W_DEF        = 16;
`endif

  // Instruction register opcodes understood by the CPU debug logic
  localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd3;

  // Command entry at default widths; the bridge derives its own
  // parameter-sized copy with the same field order.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [DR_W_DEF-1:0] data;
`ifdef JTAG_DBG_TIMESTAMP_EN
    logic [TS_W_DEF-1:0] ts;
`endif
  } jtag_entry_t;

endpackage

// File: rtl/jtag_debug_sysclk_bridge_if.sv
// Command handshake bundle between the bridge (master) and the CPU debug
// logic (slave). Optional feature macro: JTAG_DBG_TIMESTAMP_EN adds cmd_ts.
interface jtag_debug_sysclk_bridge_if #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
`ifdef JTAG_DBG_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_data;
  logic            cmd_action;
`ifdef JTAG_DBG_TIMESTAMP_EN
  logic [TS_W-1:0] cmd_ts;
`endif

  modport master (
    output cmd_valid, cmd_ir, cmd_data, cmd_action,
`ifdef JTAG_DBG_TIMESTAMP_EN
    output cmd_ts,
`endif
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, cmd_action,
`ifdef JTAG_DBG_TIMESTAMP_EN
    input  cmd_ts,
`endif
    output cmd_ready
  );

endinterface

// File: rtl/jtag_debug_sysclk_bridge_sync.sv
// Multi-flop synchroniser for a TCK-domain strobe level followed by a
// rising-edge detector. A held level yields exactly one clk-wide pulse.
module jtag_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   edge_q;

  // Shift the asynchronous level through the chain and remember last output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {SYNC_STAGES{1'b0}};
      edge_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], strobe_i};
      edge_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = chain_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/jtag_debug_sysclk_bridge.sv
// System-clock side of the CPU JTAG debug module. Synchronises update-DR and
// update-IR strobes, queues {ir, sr} captures in a command FIFO and presents
// the head over a valid/ready handshake. Back-to-back updates are buffered
// rather than overwritten; a push into a full FIFO sets sticky overflow.
// Optional feature macro: JTAG_DBG_TIMESTAMP_EN (free-running timestamp per
// entry, exported as cmd_ts).
module jtag_debug_sysclk_bridge
  import jtag_debug_pkg::*;
#(
  parameter int IR_W        = IR_W_DEF,
  parameter int DR_W        = DR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACTION_BIT  = ACTION_BIT_DEF
`ifdef JTAG_DBG_TIMESTAMP_EN
  , parameter int TS_W      = TS_W_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DR_W-1:0]          sr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  jtag_debug_sysclk_bridge_if.master cmd,
  output logic                     ir_update,
  output logic [IR_W-1:0]          ir_latched,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] data;
`ifdef JTAG_DBG_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } entry_t;

  // Strobe synchronisers
  logic udr_pulse_s;
  logic uir_pulse_s;

  jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_i (vs_udr),
    .pulse_o  (udr_pulse_s)
  );

  jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_i (vs_uir),
    .pulse_o  (uir_pulse_s)
  );

  // FIFO state
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            overflow_q, overflow_d;
  logic [IR_W-1:0] ir_latched_q, ir_latched_d;

  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_ok_s;
  logic            drop_s;
  entry_t          new_entry_s;
  entry_t          head_s;

`ifdef JTAG_DBG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running timestamp; wraps naturally at 2^TS_W
  always_comb begin
    ts_d = ts_q + TS_W'(1'b1);
  end

  // Timestamp register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= {TS_W{1'b0}};
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  assign empty_s = (fill_q == {FW{1'b0}});
  assign full_s  = (fill_q == FW'(DEPTH));

  // Assemble the entry captured in the update-DR pulse cycle
  always_comb begin
    new_entry_s      = '0;
    new_entry_s.ir   = ir_in;
    new_entry_s.data = sr;
`ifdef JTAG_DBG_TIMESTAMP_EN
    new_entry_s.ts   = ts_q;
`endif
  end

  // Push/pop arbitration, pointer/occupancy update and sticky overflow
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    overflow_d   = overflow_q;
    ir_latched_d = ir_latched_q;
    push_ok_s    = 1'b0;
    drop_s       = 1'b0;
    pop_s        = ~empty_s & cmd.cmd_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    if (udr_pulse_s) begin
      if (!full_s || pop_s) begin
        push_ok_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_ok_s = 1'b0;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1'b1);
      2'b01:   fill_d = fill_q - FW'(1'b1);
      default: fill_d = fill_q;
    endcase

    // Setting wins over clearing so a drop is never hidden
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (uir_pulse_s) begin
      ir_latched_d = ir_in;
    end else begin
      ir_latched_d = ir_latched_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      fill_q       <= {FW{1'b0}};
      overflow_q   <= 1'b0;
      ir_latched_q <= {IR_W{1'b0}};
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      overflow_q   <= overflow_d;
      ir_latched_q <= ir_latched_d;
    end
  end

  // Entry storage; stale slots are masked by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= new_entry_s;
    end
  end

  // Present the head entry, forced to zero while the FIFO is empty
  always_comb begin
    head_s         = mem_q[rd_ptr_q];
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_ir     = {IR_W{1'b0}};
    cmd.cmd_data   = {DR_W{1'b0}};
    cmd.cmd_action = 1'b0;
`ifdef JTAG_DBG_TIMESTAMP_EN
    cmd.cmd_ts     = {TS_W{1'b0}};
`endif
    if (!empty_s) begin
      cmd.cmd_valid  = 1'b1;
      cmd.cmd_ir     = head_s.ir;
      cmd.cmd_data   = head_s.data;
      cmd.cmd_action = head_s.data[ACTION_BIT];
`ifdef JTAG_DBG_TIMESTAMP_EN
      cmd.cmd_ts     = head_s.ts;
`endif
    end else begin
      cmd.cmd_valid  = 1'b0;
    end
  end

  assign ir_update  = uir_pulse_s;
  assign ir_latched = ir_latched_q;
  assign overflow   = overflow_q;
  assign fill       = fill_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
// Directed self-checking bench for jtag_debug_sysclk_bridge (default
// parameters, SYNC_STAGES=2, DEPTH=4). The timestamp scenario is compiled
// only when JTAG_DBG_TIMESTAMP_EN is defined.
module tb_jtag_debug_sysclk_bridge;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr;
  logic        vs_uir;
  logic        ir_update;
  logic [1:0]  ir_latched;
  logic        overflow;
  logic        overflow_clr;
  logic [2:0]  fill;

  int checks = 0;
  int errors = 0;

  jtag_debug_sysclk_bridge_if #(.IR_W(2), .DR_W(38)) cmd_if ();

  jtag_debug_sysclk_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .cmd          (cmd_if),
    .ir_update    (ir_update),
    .ir_latched   (ir_latched),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .fill         (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef JTAG_DBG_TIMESTAMP_EN
  // Reference timestamp counter kept by the bench
  logic [15:0] tb_ts;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= 16'd0;
    else          tb_ts <= tb_ts + 16'd1;
  end
`endif

  // One update-DR strobe; optionally pop and/or clear during the pulse cycle
  task automatic send_udr(input logic [37:0] d, input logic [1:0] ir,
                          input bit pop_with, input bit clr_with);
    @(negedge clk); sr = d; ir_in = ir; vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (pop_with) cmd_if.cmd_ready = 1'b1;
    if (clr_with) overflow_clr = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0; overflow_clr = 1'b0; vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ir_in = 2'd0; sr = 38'd0; vs_udr = 1'b0; vs_uir = 1'b0;
    overflow_clr = 1'b0; cmd_if.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", cmd_if.cmd_valid); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", overflow); end
    checks++; if (ir_update !== 1'b0 || ir_latched !== 2'd0) begin errors++; $display("FAIL rst_ir got %0b/%0d exp 0/0", ir_update, ir_latched); end
    checks++; if (cmd_if.cmd_data !== 38'd0 || cmd_if.cmd_ir !== 2'd0) begin errors++; $display("FAIL rst_head got %h/%0d exp 0/0", cmd_if.cmd_data, cmd_if.cmd_ir); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    @(negedge clk); sr = 38'h2_0000_0ABC; ir_in = 2'b01; vs_udr = 1'b1;
    @(negedge clk);
    checks++; if (cmd_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_e1 got %0b exp 0", cmd_if.cmd_valid); end
    @(negedge clk);
    checks++; if (cmd_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_e2 got %0b exp 0", cmd_if.cmd_valid); end
    @(negedge clk);
    checks++; if (cmd_if.cmd_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_e3 got %0b exp 1", cmd_if.cmd_valid); end
    checks++; if (cmd_if.cmd_data !== 38'h2_0000_0ABC) begin errors++; $display("FAIL t1_data got %h exp 2000000abc", cmd_if.cmd_data); end
    checks++; if (cmd_if.cmd_ir !== 2'd1 || cmd_if.cmd_action !== 1'b0) begin errors++; $display("FAIL t1_ir_act got %0d/%0b exp 1/0", cmd_if.cmd_ir, cmd_if.cmd_action); end
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL t1_one_entry got %0d exp 1", fill); end
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    checks++; if (fill !== 3'd0 || cmd_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL t1_drain got %0d/%0b exp 0/0", fill, cmd_if.cmd_valid); end
  endtask

  task automatic test_overflow();
    logic [37:0] v [5];
    v[0] = 38'h00_1111_1111; v[1] = 38'h01_2222_2222; v[2] = 38'h02_3333_3333;
    v[3] = 38'h03_4444_4444; v[4] = 38'h3F_5555_5555;
    for (int i = 0; i < 5; i++) send_udr(v[i], 2'(i), 1'b0, 1'b0);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL t2_fill got %0d exp 4", fill); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t2_ovf got %0b exp 1", overflow); end
    @(negedge clk); overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t2_clr got %0b exp 0", overflow); end
    send_udr(38'h3F_FFFF_FFFF, 2'd3, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t2_set_wins got %0b exp 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_data !== v[i] || cmd_if.cmd_ir !== 2'(i)) begin
        errors++; $display("FAIL t2_pop%0d got %0b/%h/%0d exp 1/%h/%0d", i, cmd_if.cmd_valid, cmd_if.cmd_data, cmd_if.cmd_ir, v[i], i);
      end
      cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    end
    checks++; if (cmd_if.cmd_valid !== 1'b0 || fill !== 3'd0 || cmd_if.cmd_data !== 38'd0) begin errors++; $display("FAIL t2_empty got %0b/%0d/%h exp 0/0/0", cmd_if.cmd_valid, fill, cmd_if.cmd_data); end
    @(negedge clk); overflow_clr = 1'b1; @(negedge clk); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t2_clr2 got %0b exp 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [37:0] v [5];
    for (int i = 0; i < 5; i++) v[i] = 38'h10_0000_0000 + 38'(i * 38'h101);
    for (int i = 0; i < 4; i++) send_udr(v[i], 2'd2, 1'b0, 1'b0);
    send_udr(v[4], 2'd3, 1'b1, 1'b0);
    checks++; if (fill !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL t3_fill_ovf got %0d/%0b exp 4/0", fill, overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (cmd_if.cmd_data !== v[i]) begin errors++; $display("FAIL t3_pop%0d got %h exp %h", i, cmd_if.cmd_data, v[i]); end
      cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL t3_drain got %0d exp 0", fill); end
  endtask

  task automatic test_ir_update();
    @(negedge clk); ir_in = 2'b10; sr = 38'h0A_BCDE_F012; vs_uir = 1'b1; vs_udr = 1'b1;
    @(negedge clk);
    checks++; if (ir_update !== 1'b0) begin errors++; $display("FAIL t4_upd_e1 got %0b exp 0", ir_update); end
    @(negedge clk);
    checks++; if (ir_update !== 1'b1 || ir_latched !== 2'd0) begin errors++; $display("FAIL t4_upd_e2 got %0b/%0d exp 1/0", ir_update, ir_latched); end
    @(negedge clk);
    checks++; if (ir_update !== 1'b0 || ir_latched !== 2'd2) begin errors++; $display("FAIL t4_upd_e3 got %0b/%0d exp 0/2", ir_update, ir_latched); end
    checks++; if (fill !== 3'd1 || cmd_if.cmd_ir !== 2'd2 || cmd_if.cmd_data !== 38'h0A_BCDE_F012) begin errors++; $display("FAIL t4_fifo got %0d/%0d/%h exp 1/2/0abcdef012", fill, cmd_if.cmd_ir, cmd_if.cmd_data); end
    @(negedge clk);
    checks++; if (ir_update !== 1'b0) begin errors++; $display("FAIL t4_no_repeat got %0b exp 0", ir_update); end
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_action_reset();
    send_udr(38'h08_0000_0123, 2'd3, 1'b0, 1'b0);
    send_udr(38'h00_0000_0456, 2'd0, 1'b0, 1'b0);
    send_udr(38'h00_0000_0789, 2'd1, 1'b0, 1'b0);
    checks++; if (cmd_if.cmd_action !== 1'b1 || fill !== 3'd3) begin errors++; $display("FAIL t5_action got %0b/%0d exp 1/3", cmd_if.cmd_action, fill); end
    @(negedge clk); #2 reset_n = 1'b0; #1;
    checks++; if (fill !== 3'd0 || cmd_if.cmd_valid !== 1'b0) begin errors++; $display("FAIL t5_async_fill got %0d/%0b exp 0/0", fill, cmd_if.cmd_valid); end
    checks++; if (cmd_if.cmd_data !== 38'd0 || cmd_if.cmd_ir !== 2'd0 || cmd_if.cmd_action !== 1'b0) begin errors++; $display("FAIL t5_async_head got %h/%0d/%0b exp 0/0/0", cmd_if.cmd_data, cmd_if.cmd_ir, cmd_if.cmd_action); end
    checks++; if (ir_latched !== 2'd0 || overflow !== 1'b0) begin errors++; $display("FAIL t5_async_ir got %0d/%0b exp 0/0", ir_latched, overflow); end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL t5_post_rst got %0d exp 0", fill); end
  endtask

`ifdef JTAG_DBG_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [15:0] exp_a;
    @(negedge clk); sr = 38'h1; vs_udr = 1'b1;
    @(negedge clk); @(negedge clk); exp_a = tb_ts;
    @(negedge clk); vs_udr = 1'b0;
    repeat (7) @(negedge clk); sr = 38'h2; vs_udr = 1'b1;
    repeat (3) @(negedge clk); vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cmd_if.cmd_ts !== exp_a) begin errors++; $display("FAIL t6_ts_a got %h exp %h", cmd_if.cmd_ts, exp_a); end
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    checks++; if (cmd_if.cmd_ts !== exp_a + 16'd10) begin errors++; $display("FAIL t6_ts_diff got %h exp %h", cmd_if.cmd_ts, exp_a + 16'd10); end
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    for (int k = 0; k < 70000 && tb_ts != 16'hFFFD; k++) @(negedge clk);
    checks++; if (tb_ts !== 16'hFFFD) begin errors++; $display("FAIL t6_wait got %h exp fffd", tb_ts); end
    vs_udr = 1'b1;
    repeat (3) @(negedge clk); vs_udr = 1'b0;
    repeat (4) @(negedge clk); vs_udr = 1'b1;
    repeat (3) @(negedge clk); vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cmd_if.cmd_ts !== 16'hFFFF) begin errors++; $display("FAIL t6_wrap_a got %h exp ffff", cmd_if.cmd_ts); end
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
    checks++; if (cmd_if.cmd_ts !== 16'h0006) begin errors++; $display("FAIL t6_wrap_b got %h exp 0006", cmd_if.cmd_ts); end
    cmd_if.cmd_ready = 1'b1; @(negedge clk); cmd_if.cmd_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_full_pop();
    test_ir_update();
    test_action_reset();
`ifdef JTAG_DBG_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
